// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative restoring unsigned divider. Divides an NUM_W-bit
//                dividend by a DEN_W-bit divisor, one quotient bit per clock,
//                behind a start/done handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_W       dividend / quotient width (default 32)
//    DEN_W       divisor / remainder width (default 16), DEN_W <= NUM_W
//  Ports
//    clk         clock, rising edge
//    rst         asynchronous active-high reset
//    start       request, sampled only while busy is low
//    dividend    unsigned dividend, sampled on the accepting edge
//    divisor     unsigned divisor, sampled on the accepting edge
//    quotient    registered quotient
//    remainder   registered remainder
//    done        one-cycle pulse, results valid
//    busy        high while iterating
//    div_by_zero qualifies the current result
//  Configuration
//    SEQ_DIVIDER_EARLY_EXIT_EN : when defined, a dividend smaller than a
//    non-zero divisor finishes on the accept edge (quotient 0).
// ============================================================================
module seq_divider #(
    parameter int NUM_W = 32,
    parameter int DEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int         c_cnt_w   = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_W - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_count;
    // Dividend bits shift out of the MSB while quotient bits shift in at the
    // LSB, so one register serves both roles.
    logic [NUM_W-1:0]   r_work;
    logic [DEN_W-1:0]   r_divisor;
    // The partial remainder is always below the divisor between iterations,
    // so DEN_W bits suffice; the extra bit only exists in the shifted value.
    logic [DEN_W-1:0]   r_prem;
    logic [NUM_W-1:0]   r_quotient;
    logic [DEN_W-1:0]   r_remainder;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_early;
    logic [DEN_W:0]     w_shifted;
    logic               w_ge;
    logic [DEN_W-1:0]   w_diff;
    logic [DEN_W-1:0]   w_prem_next;
    logic [NUM_W-1:0]   w_work_next;

    assign w_accept   = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_div_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign w_early = !w_div_zero && (dividend < NUM_W'(divisor));
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: bring in the next dividend bit, trial-subtract.
    assign w_shifted   = {r_prem, r_work[NUM_W-1]};
    assign w_ge        = (w_shifted >= {1'b0, r_divisor});
    // When w_ge holds the difference is below the divisor, so the dropped MSB
    // is always zero.
    assign w_diff      = w_shifted[DEN_W-1:0] - r_divisor;
    assign w_prem_next = w_ge ? w_diff : w_shifted[DEN_W-1:0];
    assign w_work_next = {r_work[NUM_W-2:0], w_ge};

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (w_accept) begin
                    w_state_next = (w_div_zero || w_early) ? c_st_done : c_st_run;
                end else begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_run: begin
                if (r_count == '0) begin
                    w_state_next = c_st_done;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        case (r_state)
            c_st_run:  busy = 1'b1;
            c_st_done: done = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_work      <= '0;
            r_divisor   <= '0;
            r_prem      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= divisor;
            r_work    <= dividend;
            r_prem    <= '0;
            r_count   <= c_last;
            r_dbz     <= w_div_zero;
            if (w_div_zero) begin
                r_quotient  <= '1;
                r_remainder <= dividend[DEN_W-1:0];
            end else if (w_early) begin
                r_quotient  <= '0;
                r_remainder <= dividend[DEN_W-1:0];
            end
        end else if (r_state == c_st_run) begin
            r_work  <= w_work_next;
            r_prem  <= w_prem_next;
            r_count <= r_count - 1'b1;
            // Results become visible only once the last bit is resolved.
            if (r_count == '0) begin
                r_quotient  <= w_work_next;
                r_remainder <= w_prem_next;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider. A cycle-level model
//                built from plain arithmetic (/, %) and a latency countdown
//                is compared against the DUT on every falling edge; directed
//                tests add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.NUM_W(32), .DEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left counts edges still to go before a pending result lands.
    int          m_left = 0;
    logic [31:0] m_q    = '0;
    logic [15:0] m_r    = '0;
    logic        m_dbz  = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] p_q    = '0;
    logic [15:0] p_r    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (divisor == 16'd0) begin
                    m_q    <= 32'hFFFF_FFFF;
                    m_r    <= dividend[15:0];
                    m_dbz  <= 1'b1;
                    m_done <= 1'b1;
                end else if (c_early && (dividend < {16'd0, divisor})) begin
                    m_q    <= 32'd0;
                    m_r    <= dividend[15:0];
                    m_dbz  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    p_q    <= dividend / {16'd0, divisor};
                    p_r    <= 16'(dividend % {16'd0, divisor});
                    m_dbz  <= 1'b0;
                    m_left <= 32;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic armed = 1'b0;
    always @(negedge clk) begin
        if (armed && !rst) begin
            check("done",        {63'd0, done},        {63'd0, m_done});
            check("busy",        {63'd0, busy},        {63'd0, (m_left > 0)});
            check("quotient",    {32'd0, quotient},    {32'd0, m_q});
            check("remainder",   {48'd0, remainder},   {48'd0, m_r});
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, m_dbz});
        end
    end

    // Issue one request; returns the number of edges from accept to done
    // (accept edge counted as 1). b2b issues it in the current DONE cycle.
    task automatic do_div(input logic [31:0] a, input logic [15:0] b,
                          input bit b2b, output int lat);
        if (!b2b) @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    int lat;
    int ndone;
    int exp_lat;
    logic [31:0] ra;
    logic [15:0] rb;

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient",    {32'd0, quotient},  64'd0);
        check("rst_remainder",   {48'd0, remainder}, 64'd0);
        check("rst_done",        {63'd0, done},      64'd0);
        check("rst_busy",        {63'd0, busy},      64'd0);
        check("rst_div_by_zero", {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;
        armed = 1'b1;

        // 100000 / 7
        do_div(32'd100000, 16'd7, 1'b0, lat);
        check("t1_lat", lat, 33);
        check("t1_q", quotient, 32'd14285);
        check("t1_r", remainder, 16'd5);
        check("t1_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        check("t1_done_single", done, 1'b0);

        // Large operands
        do_div(32'hFFFF_FFFF, 16'hFFFF, 1'b0, lat);
        check("t2_q", quotient, 32'h0001_0001);
        check("t2_r", remainder, 16'd0);
        do_div(32'hFFFF_FFFF, 16'd1, 1'b0, lat);
        check("t3_q", quotient, 32'hFFFF_FFFF);
        check("t3_r", remainder, 16'd0);

        // Divide by zero, then a back-to-back normal divide clears the flag
        do_div(32'd1234, 16'd0, 1'b0, lat);
        check("t4_lat", lat, 1);
        check("t4_q", quotient, 32'hFFFF_FFFF);
        check("t4_r", remainder, 16'd1234);
        check("t4_dbz", div_by_zero, 1'b1);
        do_div(32'd10, 16'd3, 1'b1, lat);
        check("t5_lat", lat, 33);
        check("t5_q", quotient, 32'd3);
        check("t5_r", remainder, 16'd1);
        check("t5_dbz", div_by_zero, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd100000; divisor = 16'd7;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin @(posedge clk); lat++; end
        @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 16'd5;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start = 1'b0;
        check("t6_busy_at_10", busy, 1'b1);
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("t6_lat", lat, 33);
        check("t6_q", quotient, 32'd14285);
        check("t6_r", remainder, 16'd5);
        // Back-to-back accept in the DONE cycle
        do_div(32'd1000, 16'd7, 1'b1, lat);
        check("t7_lat", lat, 33);
        check("t7_q", quotient, 32'd142);
        check("t7_r", remainder, 16'd6);

        // Asynchronous reset mid-run
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000000; divisor = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t8_q", quotient, 32'd0);
        check("t8_r", remainder, 16'd0);
        check("t8_busy", busy, 1'b0);
        check("t8_done", done, 1'b0);
        check("t8_dbz", div_by_zero, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("t8_no_done", ndone, 0);
        do_div(32'd81, 16'd9, 1'b0, lat);
        check("t9_lat", lat, 33);
        check("t9_q", quotient, 32'd9);
        check("t9_r", remainder, 16'd0);

        // Dividend smaller than divisor
        do_div(32'd5, 16'd9, 1'b0, lat);
        check("t10_lat", lat, c_early ? 1 : 33);
        check("t10_q", quotient, 32'd0);
        check("t10_r", remainder, 16'd5);
        check("t10_dbz", div_by_zero, 1'b0);

        // A few pseudo-random operands against the arithmetic invariant
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = 16'($urandom_range(1, 65535));
            if (i == 5) ra = {16'd0, rb} - 32'd1;
            exp_lat = (c_early && ra < {16'd0, rb}) ? 1 : 33;
            do_div(ra, rb, 1'b0, lat);
            check("rnd_lat", lat, exp_lat);
            check("rnd_invariant", quotient * {32'd0, rb} + {48'd0, remainder}, {32'd0, ra});
            check("rnd_rem_lt", {63'd0, remainder < rb}, 64'd1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
